// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer with frame-synchronous pattern select handshake.
// Optional frame counter enabled by defining VGA_CTRL_FRAME_CNT_EN.
module vga_timing_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic        cfg_valid,
  input  logic [1:0]  cfg_pattern,
  output logic        cfg_ready,
  output logic [1:0]  pattern,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        display_on,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start,
  output logic [7:0]  frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VFP_START  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VBP_START  = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {VAct, VFp, VSync, VBp} vstate_e;
  typedef enum logic [1:0] {CfgIdle, CfgPend, CfgDone} cfg_state_e;

  logic [10:0] r_hcount;
  logic [9:0]  r_vcount;
  vstate_e     r_vstate;
  logic        r_display_on;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_line_start;
  logic        r_frame_start;

  cfg_state_e  r_cfg_state;
  logic        r_cfg_ready;
  logic [1:0]  r_pending;
  logic [1:0]  r_pattern;

  logic        w_h_wrap;
  logic        w_frame_wrap;
  logic        w_frame_tick;
  logic [10:0] w_h_next;
  logic [9:0]  w_v_next;
  vstate_e     w_vstate_next;

  always_comb begin
    w_h_wrap      = (r_hcount == H_LAST);
    w_frame_wrap  = w_h_wrap && (r_vcount == V_LAST);
    w_frame_tick  = pix_en && w_frame_wrap;
    w_h_next      = w_h_wrap ? 11'd0 : r_hcount + 11'd1;
    w_v_next      = r_vcount;
    w_vstate_next = r_vstate;
    if (w_h_wrap) begin
      w_v_next = (r_vcount == V_LAST) ? 10'd0 : r_vcount + 10'd1;
      if (w_v_next == 10'd0)           w_vstate_next = VAct;
      else if (w_v_next == VFP_START)  w_vstate_next = VFp;
      else if (w_v_next == VS_START)   w_vstate_next = VSync;
      else if (w_v_next == VBP_START)  w_vstate_next = VBp;
    end
  end

  // Decoded outputs use the next counter values so they line up with hcount/vcount.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcount      <= H_LAST;
      r_vcount      <= V_LAST;
      r_vstate      <= VBp;
      r_display_on  <= 1'b0;
      r_hsync       <= !SYNC_POL;
      r_vsync       <= !SYNC_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (pix_en) begin
      r_hcount      <= w_h_next;
      r_vcount      <= w_v_next;
      r_vstate      <= w_vstate_next;
      r_display_on  <= (w_h_next < H_ACT_END) && (w_vstate_next == VAct);
      r_hsync       <= ((w_h_next >= HS_START) && (w_h_next < HS_END)) ? SYNC_POL : !SYNC_POL;
      r_vsync       <= (w_vstate_next == VSync) ? SYNC_POL : !SYNC_POL;
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_frame_wrap;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  // A request accepted on the wrap cycle is still in CfgIdle there, so it waits a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_state <= CfgIdle;
      r_cfg_ready <= 1'b1;
      r_pending   <= 2'd0;
      r_pattern   <= 2'd0;
    end else begin
      unique case (r_cfg_state)
        CfgIdle: begin
          if (cfg_valid && r_cfg_ready) begin
            r_pending   <= cfg_pattern;
            r_cfg_ready <= 1'b0;
            r_cfg_state <= CfgPend;
          end
        end
        CfgPend: begin
          if (w_frame_tick) begin
            r_pattern   <= r_pending;
            r_cfg_state <= CfgDone;
          end
        end
        CfgDone: begin
          r_cfg_ready <= 1'b1;
          r_cfg_state <= CfgIdle;
        end
        default: begin
          r_cfg_ready <= 1'b1;
          r_cfg_state <= CfgIdle;
        end
      endcase
    end
  end

`ifdef VGA_CTRL_FRAME_CNT_EN
  logic [7:0] r_frame_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_count <= 8'd0;
    end else if (w_frame_tick) begin
      r_frame_count <= r_frame_count + 8'd1;
    end
  end

  assign frame_count = r_frame_count;
`else
  assign frame_count = 8'd0;
`endif

  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign display_on  = r_display_on;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign cfg_ready   = r_cfg_ready;
  assign pattern     = r_pattern;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench for vga_timing_ctrl on a shrunken raster (15 x 12 ticks per frame).
// Honours VGA_CTRL_FRAME_CNT_EN when expecting frame_count.
module tb_vga_timing_ctrl;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2, HT = HA + HF + HS + HB;
  localparam int VA = 6, VF = 2, VS = 2, VB = 2, VT = VA + VF + VS + VB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [1:0]  cfg_pattern = 2'd0;
  logic        cfg_ready;
  logic [1:0]  pattern;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        display_on, hsync, vsync, line_start, frame_start;
  logic [7:0]  frame_count;

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .cfg_valid(cfg_valid), .cfg_pattern(cfg_pattern), .cfg_ready(cfg_ready),
    .pattern(pattern), .hcount(hcount), .vcount(vcount),
    .display_on(display_on), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference raster/handshake state
  int         mh, mv, m_fc;
  logic       m_ls, m_fs, m_ready, m_done;
  logic [1:0] m_pat, m_pend;

  typedef struct {
    logic       pe;
    logic       v;
    logic [1:0] p;
    int         h;
    int         vc;
    logic       d, hs, vs, ls, fs, rdy;
    logic [1:0] pat;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mh = HT - 1; mv = VT - 1; m_fc = 0;
    m_ls = 1'b0; m_fs = 1'b0; m_ready = 1'b1; m_done = 1'b0;
    m_pat = 2'd0; m_pend = 2'd0;
  endtask

  task automatic model_update(input logic pe, input logic v, input logic [1:0] p);
    logic wrap;
    wrap = pe && (mh == HT - 1) && (mv == VT - 1);
    if (m_done) begin
      m_ready = 1'b1; m_done = 1'b0;
    end else if (!m_ready && wrap) begin
      m_pat = m_pend; m_done = 1'b1;
    end else if (m_ready && v) begin
      m_pend = p; m_ready = 1'b0;
    end
    if (pe) begin
      m_ls = (mh == HT - 1);
      m_fs = wrap;
      mh = mh + 1;
      if (mh == HT) begin
        mh = 0;
        mv = (mv + 1) % VT;
      end
      if (wrap) m_fc = (m_fc + 1) % 256;
    end else begin
      m_ls = 1'b0; m_fs = 1'b0;
    end
  endtask

  task automatic check_model();
    chk("hcount", 32'(hcount), 32'(mh));
    chk("vcount", 32'(vcount), 32'(mv));
    chk("display_on", 32'(display_on), 32'((mh < HA) && (mv < VA)));
    chk("hsync", 32'(hsync), 32'(!((mh >= HA + HF) && (mh < HA + HF + HS))));
    chk("vsync", 32'(vsync), 32'(!((mv >= VA + VF) && (mv < VA + VF + VS))));
    chk("line_start", 32'(line_start), 32'(m_ls));
    chk("frame_start", 32'(frame_start), 32'(m_fs));
    chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
    chk("pattern", 32'(pattern), 32'(m_pat));
`ifdef VGA_CTRL_FRAME_CNT_EN
    chk("frame_count", 32'(frame_count), 32'(m_fc));
`else
    chk("frame_count", 32'(frame_count), 32'd0);
`endif
  endtask

  task automatic step(input logic pe, input logic v, input logic [1:0] p);
    pix_en = pe; cfg_valid = v; cfg_pattern = p;
    model_update(pe, v, p);
    @(posedge clk); #1;
    check_model();
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_hcount"}, 32'(hcount), 32'(HT - 1));
    chk({nm, "_vcount"}, 32'(vcount), 32'(VT - 1));
    chk({nm, "_display_on"}, 32'(display_on), 32'd0);
    chk({nm, "_hsync"}, 32'(hsync), 32'd1);
    chk({nm, "_vsync"}, 32'(vsync), 32'd1);
    chk({nm, "_line_start"}, 32'(line_start), 32'd0);
    chk({nm, "_frame_start"}, 32'(frame_start), 32'd0);
    chk({nm, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
    chk({nm, "_pattern"}, 32'(pattern), 32'd0);
    chk({nm, "_frame_count"}, 32'(frame_count), 32'd0);
  endtask

  int hs_cnt, vs_cnt, d_cnt, ls_cnt, fs_cnt, seen_fs;

  initial begin
    //          pe    v     p     h  v  d     hs    vs    ls    fs    rdy   pat
    tbl[0] = '{1'b1, 1'b0, 2'd0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0};
    tbl[1] = '{1'b0, 1'b0, 2'd0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0};
    tbl[2] = '{1'b1, 1'b1, 2'd2, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[3] = '{1'b1, 1'b1, 2'd3, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[4] = '{1'b0, 1'b1, 2'd3, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[5] = '{1'b1, 1'b0, 2'd0, 3, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};

    model_reset();
    #12;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      pix_en = tbl[i].pe; cfg_valid = tbl[i].v; cfg_pattern = tbl[i].p;
      model_update(tbl[i].pe, tbl[i].v, tbl[i].p);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_hcount", i), 32'(hcount), 32'(tbl[i].h));
      chk($sformatf("vec%0d_vcount", i), 32'(vcount), 32'(tbl[i].vc));
      chk($sformatf("vec%0d_display_on", i), 32'(display_on), 32'(tbl[i].d));
      chk($sformatf("vec%0d_hsync", i), 32'(hsync), 32'(tbl[i].hs));
      chk($sformatf("vec%0d_vsync", i), 32'(vsync), 32'(tbl[i].vs));
      chk($sformatf("vec%0d_line_start", i), 32'(line_start), 32'(tbl[i].ls));
      chk($sformatf("vec%0d_frame_start", i), 32'(frame_start), 32'(tbl[i].fs));
      chk($sformatf("vec%0d_cfg_ready", i), 32'(cfg_ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_pattern", i), 32'(pattern), 32'(tbl[i].pat));
    end

    // Pending pattern 2 must land exactly on frame_start; held request for 3 is ignored.
    seen_fs = 0;
    for (int i = 0; i < 4 * HT * VT; i++) begin
      step(1'b1, 1'b1, 2'd3);
      if (frame_start) begin
        seen_fs = 1;
        break;
      end
      chk("pattern_held_before_fs", 32'(pattern), 32'd0);
    end
    chk("fs_seen", 32'(seen_fs), 32'd1);
    chk("pattern_applied", 32'(pattern), 32'd2);
    chk("ready_low_on_fs", 32'(cfg_ready), 32'd0);
    step(1'b1, 1'b0, 2'd0);
    chk("ready_back", 32'(cfg_ready), 32'd1);
    chk("pattern_kept", 32'(pattern), 32'd2);

    // One full frame of continuous ticks: aggregate timing counts.
    hs_cnt = 0; vs_cnt = 0; d_cnt = 0; ls_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < HT * VT; i++) begin
      step(1'b1, 1'b0, 2'd0);
      if (!hsync) hs_cnt++;
      if (!vsync) vs_cnt++;
      if (display_on) d_cnt++;
      if (line_start) ls_cnt++;
      if (frame_start) fs_cnt++;
    end
    chk("frame_hsync_ticks", 32'(hs_cnt), 32'(HS * VT));
    chk("frame_vsync_ticks", 32'(vs_cnt), 32'(VS * HT));
    chk("frame_display_ticks", 32'(d_cnt), 32'(HA * VA));
    chk("frame_line_starts", 32'(ls_cnt), 32'(VT));
    chk("frame_starts_per_frame", 32'(fs_cnt), 32'd1);

    // Request accepted on the wrap cycle applies one frame later.
    for (int i = 0; i < 2 * HT * VT && !(mh == HT - 1 && mv == VT - 1); i++)
      step(1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b1, 2'd1);
    chk("wrap_accept_fs", 32'(frame_start), 32'd1);
    chk("wrap_accept_not_applied", 32'(pattern), 32'd2);
    chk("wrap_accept_ready", 32'(cfg_ready), 32'd0);
    for (int i = 0; i < HT * VT; i++) step(1'b1, 1'b0, 2'd0);
    chk("wrap_accept_applied", 32'(pattern), 32'd1);
    chk("wrap_accept_applied_fs", 32'(frame_start), 32'd1);
    step(1'b0, 1'b0, 2'd0);

    // Sparse pixel ticks: outputs hold, strobes stay one cycle.
    for (int i = 0; i < 80; i++) step((i % 4) == 0, 1'b0, 2'd0);

    // Async reset mid-frame with a request pending.
    for (int i = 0; i < 2 * HT * VT && !(mh == 5 && mv == 3); i++) step(1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b1, 2'd3);
    chk("pending_before_reset", 32'(cfg_ready), 32'd0);
    step(1'b1, 1'b0, 2'd0);
    #2 rst_n = 1'b0;
    pix_en = 1'b0; cfg_valid = 1'b0;
    #1 chk_reset_vals("async_reset");
    @(posedge clk); #1;
    chk_reset_vals("held_reset");
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check_model();

    for (int i = 0; i < 4 * HT * VT && m_fc < 3; i++) step(1'b1, 1'b0, 2'd0);
    chk("pattern_after_reset", 32'(pattern), 32'd0);
`ifdef VGA_CTRL_FRAME_CNT_EN
    chk("frame_count_three", 32'(frame_count), 32'd3);
`else
    chk("frame_count_off", 32'(frame_count), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Raster sequencer for the VGA pixel path. Generates the `hcount`/`vcount`/`display_on` stream consumed by the colour-pattern stage, plus `hsync`/`vsync` for the connector. Accepts pattern-select changes through a valid/ready handshake and applies them only at frame boundaries, so a frame never shows two patterns.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch
- `H_SYNC`, 96: hsync width
- `H_BP`, 48: horizontal back porch
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10: vertical front porch
- `V_SYNC`, 2: vsync width
- `V_BP`, 33: vertical back porch
- `SYNC_POL`, 0: asserted sync level (0 = active-low)

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `pix_en`  in  1  pixel tick; the raster advances only on cycles with `pix_en`=1
- `cfg_valid`  in  1  pattern change request
- `cfg_pattern`  in  2  requested pattern
- `cfg_ready`  out  1  controller can accept a request
- `pattern`  out  2  pattern in force for the current frame
- `hcount`  out  11  pixel column
- `vcount`  out  10  line number
- `display_on`  out  1  current (hcount, vcount) is visible
- `hsync`  out  1  horizontal sync
- `vsync`  out  1  vertical sync
- `line_start`  out  1  one-cycle pulse, hcount just became 0
- `frame_start`  out  1  one-cycle pulse, (hcount, vcount) just became (0, 0)
- `frame_count`  out  8  frames started (see Configuration)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Reset state: hcount=H_TOTAL-1, vcount=V_TOTAL-1, display_on=0, hsync=vsync=!SYNC_POL, line_start=frame_start=0, pattern=0, cfg_ready=1, frame_count=0. The first `pix_en` moves the raster to (0, 0) and pulses both start strobes.
- On `pix_en`: hcount increments; at H_TOTAL-1 it wraps to 0 and vcount increments; vcount wraps V_TOTAL-1 -> 0.
- Vertical FSM: V_ACT -> V_FP -> V_SYNC -> V_BP -> V_ACT. Transitions occur only on line wraps, when vcount enters V_ACTIVE, V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC, and 0 respectively. Reset state is V_BP.
- display_on = (hcount < H_ACTIVE) && FSM in V_ACT.
- hsync asserted for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] ([656, 751]).
- vsync asserted while the FSM is in V_SYNC (vcount 490–491).
- Config handshake: a transfer occurs when cfg_valid && cfg_ready. The value is latched into a pending register and cfg_ready drops. At the next frame_start, pattern takes the pending value. cfg_ready returns to 1 on the following cycle.
- A transfer accepted in the same cycle as a frame wrap does not apply at that wrap. It applies at the next one.
- While cfg_ready=0, cfg_valid is ignored and cfg_pattern may change freely.
- `pix_en`=0 freezes every raster output. Strobes are 0 on cycles without `pix_en`.

## Timing
- All outputs are registered. display_on, hsync, vsync and the strobes are computed from the next counter values, so they are aligned with hcount/vcount in the same cycle; there is zero skew between them.
- pattern changes in the same cycle that frame_start is 1.
- Handshake latency from acceptance to pattern update: up to one frame (V_TOTAL·H_TOTAL pixel ticks). cfg_ready is low from the cycle after acceptance through the cycle of the applying frame_start.
- An `rst_n` assertion at any point, including mid-frame or with a request pending, returns all state to the reset values immediately and discards the pending request.

## Configuration
- `VGA_CTRL_FRAME_CNT_EN` defined: frame_count increments on every frame_start and wraps 255 -> 0.
- Not defined: frame_count is constant 0 and no counter flops are built.

## Test plan
- Reset, then 1 `pix_en` -> hcount=0, vcount=0, display_on=1, frame_start=1, line_start=1.
- Continuous `pix_en` for one line -> hsync asserted exactly for hcount 656..751 (96 ticks); display_on=1 for hcount 0..639; line_start pulses at the tick after hcount=799.
- Full frame -> vsync asserted for vcount 490–491; frame_start recurs every 420000 ticks; display_on=0 for vcount ≥480.
- cfg_pattern=2 accepted mid-frame -> cfg_ready=0, pattern stays 0 until the next frame_start, then pattern=2; cfg_ready=1 one cycle later; a cfg_pattern=3 request held during the pending period is not accepted.
- `pix_en` toggling 1-of-4 cycles -> counts advance once per tick, outputs hold between ticks, strobes last one cycle.
- `rst_n` pulsed low at (hcount=300, vcount=200) with a request pending -> all outputs back to reset values, pattern=0; with `VGA_CTRL_FRAME_CNT_EN`, frame_count=0 and reaches 3 after three frames.
